// File: rtl/fm_3d_mu_rd_arb_pkg.sv
// Shared widths, FSM state type and arbitration helper for the memory-unit read arbiter.
package fm_3d_mu_rd_arb_pkg;

  localparam int unsigned IB_ADDR_WIDTH = 28;
  localparam int unsigned IB_LEN_WIDTH  = 6;
  localparam int unsigned IB_DATA_WIDTH = 32;
  localparam int unsigned TAG_DEPTH     = 4;

  typedef enum logic {
    StIdle,
    StReq
  } req_state_e;

  // Round-robin pick between two clients; returns the winning client id.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1 & ~req0;
  endfunction

endpackage

// File: rtl/fm_3d_mu_tag_fifo.sv
// Outstanding-read tag FIFO: holds {client id, burst length} for each accepted request.
module fm_3d_mu_tag_fifo #(
  parameter int unsigned P_DEPTH     = 4,
  parameter int unsigned P_LEN_WIDTH = 6
) (
  input  logic                   clk_core,
  input  logic                   rst_x,
  input  logic                   push,
  input  logic                   push_id,
  input  logic [P_LEN_WIDTH-1:0] push_len,
  input  logic                   pop,
  output logic                   head_id,
  output logic [P_LEN_WIDTH-1:0] head_len,
  output logic                   full,
  output logic                   empty
);

  // P_DEPTH must be a power of two, at least 2.
  localparam int unsigned AW = $clog2(P_DEPTH);

  logic [AW:0]                             wp_q, rp_q;
  logic [P_DEPTH-1:0]                      id_q;
  logic [P_DEPTH-1:0][P_LEN_WIDTH-1:0]     len_q;
  logic                                    do_push, do_pop;

  // Extra MSB on the pointers distinguishes full from empty.
  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_id  = id_q[rp_q[AW-1:0]];
  assign head_len = len_q[rp_q[AW-1:0]];

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      wp_q  <= '0;
      rp_q  <= '0;
      id_q  <= '0;
      len_q <= '0;
    end else begin
      if (do_push) begin
        id_q[wp_q[AW-1:0]]  <= push_id;
        len_q[wp_q[AW-1:0]] <= push_len;
        wp_q                <= wp_q + 1'b1;
      end
      if (do_pop) begin
        rp_q <= rp_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fm_3d_mu_rd_arb.sv
// Two-client read arbiter: round-robin request grant, tag FIFO for in-order read-data routing.
module fm_3d_mu_rd_arb
  import fm_3d_mu_rd_arb_pkg::*;
#(
  parameter int unsigned P_IB_ADDR_WIDTH = IB_ADDR_WIDTH,
  parameter int unsigned P_IB_LEN_WIDTH  = IB_LEN_WIDTH,
  parameter int unsigned P_IB_DATA_WIDTH = IB_DATA_WIDTH,
  parameter int unsigned P_TAG_DEPTH     = TAG_DEPTH
) (
  input  logic                       clk_core,
  input  logic                       rst_x,
  input  logic                       i_req_c0,
  input  logic [P_IB_ADDR_WIDTH-1:0] i_adrs_c0,
  input  logic [P_IB_LEN_WIDTH-1:0]  i_len_c0,
  output logic                       o_ack_c0,
  output logic                       o_strr_c0,
  output logic [P_IB_DATA_WIDTH-1:0] o_dbr_c0,
  input  logic                       i_req_c1,
  input  logic [P_IB_ADDR_WIDTH-1:0] i_adrs_c1,
  input  logic [P_IB_LEN_WIDTH-1:0]  i_len_c1,
  output logic                       o_ack_c1,
  output logic                       o_strr_c1,
  output logic [P_IB_DATA_WIDTH-1:0] o_dbr_c1,
  output logic                       o_req_co,
  output logic [P_IB_ADDR_WIDTH-1:0] o_adrs_co,
  output logic [P_IB_LEN_WIDTH-1:0]  o_len_co,
  input  logic                       i_ack_co,
  input  logic                       i_strr_co,
  input  logic [P_IB_DATA_WIDTH-1:0] i_dbr_co,
  output logic                       o_err
);

  req_state_e                 state_q;
  logic                       gnt_q, last_q;
  logic [P_IB_ADDR_WIDTH-1:0] adrs_q;
  logic [P_IB_LEN_WIDTH-1:0]  len_q;
  logic [P_IB_LEN_WIDTH-1:0]  beat_q, beat_d, beat_inc;
  logic                       err_q, err_d;

  logic                       ack_fire, any_req, win;
  logic                       fifo_full, fifo_empty, head_id;
  logic [P_IB_LEN_WIDTH-1:0]  head_len;
  logic                       strr_fire, pop;

  assign ack_fire = i_ack_co & (state_q == StReq);
  assign any_req  = i_req_c0 | i_req_c1;
  assign win      = rr_pick(i_req_c0, i_req_c1, last_q);

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      adrs_q  <= '0;
      len_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req && !fifo_full && !ack_fire) begin
            state_q <= StReq;
            gnt_q   <= win;
            last_q  <= win;
            adrs_q  <= win ? i_adrs_c1 : i_adrs_c0;
            len_q   <= win ? i_len_c1 : i_len_c0;
          end
        end
        StReq: begin
          if (i_ack_co) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_req_co  = (state_q == StReq);
  assign o_adrs_co = adrs_q;
  assign o_len_co  = len_q;
  assign o_ack_c0  = ack_fire & ~gnt_q;
  assign o_ack_c1  = ack_fire & gnt_q;

  fm_3d_mu_tag_fifo #(
    .P_DEPTH     (P_TAG_DEPTH),
    .P_LEN_WIDTH (P_IB_LEN_WIDTH)
  ) u_tag_fifo (
    .clk_core (clk_core),
    .rst_x    (rst_x),
    .push     (ack_fire),
    .push_id  (gnt_q),
    .push_len (len_q),
    .pop      (pop),
    .head_id  (head_id),
    .head_len (head_len),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Strobes with nothing outstanding are dropped and flagged.
  assign strr_fire = i_strr_co & ~fifo_empty;
  assign beat_inc  = beat_q + 1'b1;
  assign pop       = strr_fire & (beat_inc == head_len);

  always_comb begin
    beat_d = beat_q;
    err_d  = err_q | (i_strr_co & fifo_empty);
    if (pop) begin
      beat_d = '0;
    end else if (strr_fire) begin
      beat_d = beat_inc;
    end
  end

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      err_q  <= err_d;
    end
  end

  assign o_strr_c0 = strr_fire & ~head_id;
  assign o_strr_c1 = strr_fire & head_id;
  assign o_dbr_c0  = i_dbr_co;
  assign o_dbr_c1  = i_dbr_co;
  assign o_err     = err_q;

endmodule

// File: tb/tb_fm_3d_mu_rd_arb.sv
// Directed self-checking bench for fm_3d_mu_rd_arb.
module tb_fm_3d_mu_rd_arb;

  localparam int unsigned AW = 28;
  localparam int unsigned LW = 6;
  localparam int unsigned DW = 32;

  logic          clk_core = 1'b0;
  logic          rst_x;
  logic          i_req_c0, i_req_c1, i_ack_co, i_strr_co;
  logic [AW-1:0] i_adrs_c0, i_adrs_c1;
  logic [LW-1:0] i_len_c0, i_len_c1;
  logic [DW-1:0] i_dbr_co;
  logic          o_ack_c0, o_ack_c1, o_strr_c0, o_strr_c1, o_req_co, o_err;
  logic [DW-1:0] o_dbr_c0, o_dbr_c1;
  logic [AW-1:0] o_adrs_co;
  logic [LW-1:0] o_len_co;

  int n_checks = 0;
  int n_fails  = 0;

  fm_3d_mu_rd_arb dut (
    .clk_core  (clk_core),
    .rst_x     (rst_x),
    .i_req_c0  (i_req_c0),
    .i_adrs_c0 (i_adrs_c0),
    .i_len_c0  (i_len_c0),
    .o_ack_c0  (o_ack_c0),
    .o_strr_c0 (o_strr_c0),
    .o_dbr_c0  (o_dbr_c0),
    .i_req_c1  (i_req_c1),
    .i_adrs_c1 (i_adrs_c1),
    .i_len_c1  (i_len_c1),
    .o_ack_c1  (o_ack_c1),
    .o_strr_c1 (o_strr_c1),
    .o_dbr_c1  (o_dbr_c1),
    .o_req_co  (o_req_co),
    .o_adrs_co (o_adrs_co),
    .o_len_co  (o_len_co),
    .i_ack_co  (i_ack_co),
    .i_strr_co (i_strr_co),
    .i_dbr_co  (i_dbr_co),
    .o_err     (o_err)
  );

  always #5 clk_core = ~clk_core;

  // Zero-length client requests are illegal.
  always @(posedge clk_core) begin
    if (rst_x && ((i_req_c0 && i_len_c0 == '0) || (i_req_c1 && i_len_c1 == '0))) begin
      n_fails++;
      $display("FAIL len_zero: client request with len 0 at %0t", $time);
    end
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_c0  = 1'b0;
    i_req_c1  = 1'b0;
    i_ack_co  = 1'b0;
    i_strr_co = 1'b0;
  endtask

  task automatic do_reset();
    rst_x = 1'b0;
    idle_inputs();
    #2;
    rst_x = 1'b1;
    tick();
  endtask

  task automatic wait_req(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (o_req_co === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Raise a single-client request, wait for the memory request, ack it, drop the request.
  task automatic do_req(input bit c, input logic [AW-1:0] a, input logic [LW-1:0] l,
                        output bit ok);
    if (c) begin
      i_req_c1 = 1'b1; i_adrs_c1 = a; i_len_c1 = l;
    end else begin
      i_req_c0 = 1'b1; i_adrs_c0 = a; i_len_c0 = l;
    end
    wait_req(20, ok);
    if (ok) begin
      i_ack_co = 1'b1;
      tick();
      i_ack_co = 1'b0;
    end
    i_req_c0 = 1'b0;
    i_req_c1 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    rst_x     = 1'b0;
    i_strr_co = 1'b1;
    tick();
    n_checks++;
    if (o_req_co !== 1'b0) begin n_fails++; $display("FAIL rst_req: got %b want 0", o_req_co); end
    n_checks++;
    if (o_adrs_co !== '0) begin n_fails++; $display("FAIL rst_adrs: got %h want 0", o_adrs_co); end
    n_checks++;
    if (o_len_co !== '0) begin n_fails++; $display("FAIL rst_len: got %h want 0", o_len_co); end
    n_checks++;
    if ({o_ack_c1, o_ack_c0} !== 2'b00) begin
      n_fails++; $display("FAIL rst_ack: got %b want 00", {o_ack_c1, o_ack_c0});
    end
    n_checks++;
    if ({o_strr_c1, o_strr_c0} !== 2'b00) begin
      n_fails++; $display("FAIL rst_strr: got %b want 00", {o_strr_c1, o_strr_c0});
    end
    n_checks++;
    if (o_err !== 1'b0) begin n_fails++; $display("FAIL rst_err: got %b want 0", o_err); end
    i_strr_co = 1'b0;
    rst_x     = 1'b1;
    tick();
  endtask

  task automatic test_single();
    i_req_c0 = 1'b1; i_adrs_c0 = 28'h100; i_len_c0 = 6'd4;
    #1;
    n_checks++;
    if (o_req_co !== 1'b0) begin n_fails++; $display("FAIL single_req_early: got %b want 0", o_req_co); end
    tick();
    n_checks++;
    if (o_req_co !== 1'b1) begin n_fails++; $display("FAIL single_req: got %b want 1", o_req_co); end
    n_checks++;
    if (o_adrs_co !== 28'h100) begin
      n_fails++; $display("FAIL single_adrs: got %h want 100", o_adrs_co);
    end
    n_checks++;
    if (o_len_co !== 6'd4) begin n_fails++; $display("FAIL single_len: got %0d want 4", o_len_co); end
    n_checks++;
    if (o_ack_c0 !== 1'b0) begin n_fails++; $display("FAIL single_noack: got %b want 0", o_ack_c0); end
    tick();
    n_checks++;
    if (o_adrs_co !== 28'h100 || o_req_co !== 1'b1) begin
      n_fails++; $display("FAIL single_stable: got req %b adrs %h want 1 100", o_req_co, o_adrs_co);
    end
    i_ack_co = 1'b1;
    #1;
    n_checks++;
    if ({o_ack_c1, o_ack_c0} !== 2'b01) begin
      n_fails++; $display("FAIL single_ack: got %b want 01", {o_ack_c1, o_ack_c0});
    end
    tick();
    i_ack_co = 1'b0;
    i_req_c0 = 1'b0;
    #1;
    n_checks++;
    if (o_req_co !== 1'b0 || o_ack_c0 !== 1'b0) begin
      n_fails++; $display("FAIL single_done: got req %b ack %b want 0 0", o_req_co, o_ack_c0);
    end
    for (int i = 0; i < 4; i++) begin
      i_strr_co = 1'b1;
      i_dbr_co  = 32'hA000_0000 + i;
      #1;
      n_checks++;
      if ({o_strr_c1, o_strr_c0} !== 2'b01) begin
        n_fails++; $display("FAIL single_beat%0d: got %b want 01", i, {o_strr_c1, o_strr_c0});
      end
      n_checks++;
      if (o_dbr_c0 !== 32'hA000_0000 + i || o_dbr_c1 !== 32'hA000_0000 + i) begin
        n_fails++; $display("FAIL single_dbr%0d: got %h/%h want %h", i, o_dbr_c0, o_dbr_c1,
                            32'hA000_0000 + i);
      end
      tick();
    end
    i_strr_co = 1'b0;
    #1;
    n_checks++;
    if (o_err !== 1'b0) begin n_fails++; $display("FAIL single_err: got %b want 0", o_err); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] exp;
    do_reset();
    i_req_c0 = 1'b1; i_adrs_c0 = 28'h200; i_len_c0 = 6'd1;
    i_req_c1 = 1'b1; i_adrs_c1 = 28'h300; i_len_c1 = 6'd1;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 1) ? 2'b10 : 2'b01;
      wait_req(10, ok);
      n_checks++;
      if (!ok) begin n_fails++; $display("FAIL rr_timeout%0d: got no request want request", k); end
      i_ack_co = 1'b1;
      #1;
      n_checks++;
      if ({o_ack_c1, o_ack_c0} !== exp) begin
        n_fails++; $display("FAIL rr_ack%0d: got %b want %b", k, {o_ack_c1, o_ack_c0}, exp);
      end
      n_checks++;
      if (o_adrs_co !== (exp[1] ? 28'h300 : 28'h200)) begin
        n_fails++; $display("FAIL rr_adrs%0d: got %h want %h", k, o_adrs_co,
                            exp[1] ? 28'h300 : 28'h200);
      end
      tick();
      i_ack_co = 1'b0;
    end
    i_req_c0 = 1'b0;
    i_req_c1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 1) ? 2'b10 : 2'b01;
      i_strr_co = 1'b1;
      #1;
      n_checks++;
      if ({o_strr_c1, o_strr_c0} !== exp) begin
        n_fails++; $display("FAIL rr_beat%0d: got %b want %b", k, {o_strr_c1, o_strr_c0}, exp);
      end
      tick();
    end
    i_strr_co = 1'b0;
  endtask

  task automatic test_full();
    bit ok;
    bit seen;
    logic [1:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 28'h1000 + 28'(i * 64), 6'd2, ok);
      n_checks++;
      if (!ok) begin n_fails++; $display("FAIL full_fill%0d: got no request want request", i); end
    end
    i_req_c1 = 1'b1; i_adrs_c1 = 28'h400; i_len_c1 = 6'd1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_req_co !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fails++; $display("FAIL full_blocked: got req while full want none"); end
    i_strr_co = 1'b1;
    tick();
    n_checks++;
    if (o_req_co !== 1'b0) begin n_fails++; $display("FAIL full_mid: got %b want 0", o_req_co); end
    #1;
    n_checks++;
    if ({o_strr_c1, o_strr_c0} !== 2'b01) begin
      n_fails++; $display("FAIL full_last: got %b want 01", {o_strr_c1, o_strr_c0});
    end
    tick();
    i_strr_co = 1'b0;
    n_checks++;
    if (o_req_co !== 1'b0) begin n_fails++; $display("FAIL full_popped: got %b want 0", o_req_co); end
    tick();
    n_checks++;
    if (o_req_co !== 1'b1 || o_adrs_co !== 28'h400) begin
      n_fails++; $display("FAIL full_grant: got req %b adrs %h want 1 400", o_req_co, o_adrs_co);
    end
    i_ack_co = 1'b1;
    #1;
    n_checks++;
    if ({o_ack_c1, o_ack_c0} !== 2'b10) begin
      n_fails++; $display("FAIL full_ack: got %b want 10", {o_ack_c1, o_ack_c0});
    end
    tick();
    i_ack_co = 1'b0;
    i_req_c1 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      exp = (k < 6) ? 2'b01 : 2'b10;
      i_strr_co = 1'b1;
      #1;
      n_checks++;
      if ({o_strr_c1, o_strr_c0} !== exp) begin
        n_fails++; $display("FAIL full_drain%0d: got %b want %b", k, {o_strr_c1, o_strr_c0}, exp);
      end
      tick();
    end
    i_strr_co = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    do_req(1'b0, 28'h500, 6'd2, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL b2b_a: got no request want request"); end
    i_req_c1 = 1'b1; i_adrs_c1 = 28'h600; i_len_c1 = 6'd3;
    wait_req(10, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL b2b_b: got no request want request"); end
    i_strr_co = 1'b1;
    tick();
    i_ack_co = 1'b1;
    #1;
    n_checks++;
    if ({o_strr_c1, o_strr_c0, o_ack_c1, o_ack_c0} !== 4'b0110) begin
      n_fails++; $display("FAIL b2b_overlap: got strr/ack %b want 0110",
                          {o_strr_c1, o_strr_c0, o_ack_c1, o_ack_c0});
    end
    tick();
    i_ack_co = 1'b0;
    i_req_c1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({o_strr_c1, o_strr_c0} !== 2'b10) begin
        n_fails++; $display("FAIL b2b_beat%0d: got %b want 10", k, {o_strr_c1, o_strr_c0});
      end
      tick();
    end
    #1;
    n_checks++;
    if ({o_strr_c1, o_strr_c0} !== 2'b00) begin
      n_fails++; $display("FAIL b2b_extra: got %b want 00", {o_strr_c1, o_strr_c0});
    end
    tick();
    i_strr_co = 1'b0;
    n_checks++;
    if (o_err !== 1'b1) begin n_fails++; $display("FAIL b2b_err: got %b want 1", o_err); end
  endtask

  task automatic test_err();
    do_reset();
    i_strr_co = 1'b1;
    #1;
    n_checks++;
    if ({o_strr_c1, o_strr_c0} !== 2'b00) begin
      n_fails++; $display("FAIL err_strr: got %b want 00", {o_strr_c1, o_strr_c0});
    end
    n_checks++;
    if (o_err !== 1'b0) begin n_fails++; $display("FAIL err_pre: got %b want 0", o_err); end
    tick();
    i_strr_co = 1'b0;
    n_checks++;
    if (o_err !== 1'b1) begin n_fails++; $display("FAIL err_set: got %b want 1", o_err); end
    tick(); tick(); tick();
    n_checks++;
    if (o_err !== 1'b1) begin n_fails++; $display("FAIL err_sticky: got %b want 1", o_err); end
    rst_x = 1'b0;
    #1;
    n_checks++;
    if (o_err !== 1'b0) begin n_fails++; $display("FAIL err_clear: got %b want 0", o_err); end
    rst_x = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    do_reset();
    do_req(1'b0, 28'h700, 6'd8, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL mid_req: got no request want request"); end
    i_strr_co = 1'b1;
    tick();
    #1;
    n_checks++;
    if (o_strr_c0 !== 1'b1) begin n_fails++; $display("FAIL mid_beat2: got %b want 1", o_strr_c0); end
    rst_x = 1'b0;
    #1;
    n_checks++;
    if ({o_strr_c1, o_strr_c0, o_req_co, o_err} !== 4'b0000 || o_adrs_co !== '0 ||
        o_len_co !== '0) begin
      n_fails++; $display("FAIL mid_rst_out: got strr %b req %b err %b adrs %h len %h want zeros",
                          {o_strr_c1, o_strr_c0}, o_req_co, o_err, o_adrs_co, o_len_co);
    end
    i_strr_co = 1'b0;
    tick();
    rst_x     = 1'b1;
    i_strr_co = 1'b1;
    #1;
    n_checks++;
    if ({o_strr_c1, o_strr_c0} !== 2'b00) begin
      n_fails++; $display("FAIL mid_flushed: got %b want 00", {o_strr_c1, o_strr_c0});
    end
    tick();
    i_strr_co = 1'b0;
    n_checks++;
    if (o_err !== 1'b1) begin n_fails++; $display("FAIL mid_err: got %b want 1", o_err); end
    i_req_c0 = 1'b1; i_adrs_c0 = 28'h800; i_len_c0 = 6'd1;
    i_req_c1 = 1'b1; i_adrs_c1 = 28'h900; i_len_c1 = 6'd1;
    wait_req(10, ok);
    n_checks++;
    if (!ok || o_adrs_co !== 28'h800) begin
      n_fails++; $display("FAIL mid_prio: got req %b adrs %h want 1 800", ok, o_adrs_co);
    end
    i_ack_co = 1'b1;
    #1;
    n_checks++;
    if ({o_ack_c1, o_ack_c0} !== 2'b01) begin
      n_fails++; $display("FAIL mid_ack: got %b want 01", {o_ack_c1, o_ack_c0});
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    rst_x     = 1'b1;
    i_adrs_c0 = '0;
    i_adrs_c1 = '0;
    i_len_c0  = 6'd1;
    i_len_c1  = 6'd1;
    i_dbr_co  = '0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_back_to_back();
    test_err();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
